// File: rtl/dmem_io_pkg.sv
// Shared constants for the data-side bus responder: I/O page register
// addresses, CTRL bit positions and the compare register reset value.
package dmem_io_pkg;

    localparam logic [7:0] ADDR_PORT_OUT  = 8'hF0;
    localparam logic [7:0] ADDR_PORT_IN   = 8'hF1;
    localparam logic [7:0] ADDR_TIMER_CNT = 8'hF2;
    localparam logic [7:0] ADDR_TIMER_CMP = 8'hF3;
    localparam logic [7:0] ADDR_CTRL      = 8'hF4;
    localparam logic [7:0] ADDR_STATUS    = 8'hF5;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_AUTO_CLR = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;

    localparam logic [7:0] TIMER_CMP_RST = 8'hFF;

endpackage

// File: rtl/io_timer.sv
// 8-bit compare timer: count, compare, CTRL and STATUS registers with a
// level interrupt. Register writes arrive as per-register strobes.
module io_timer
    import dmem_io_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cnt_we,
    input  logic       cmp_we,
    input  logic       ctrl_we,
    input  logic       status_w1c,
    input  logic [7:0] wdata,
    output logic [7:0] cnt,
    output logic [7:0] cmp,
    output logic [7:0] ctrl,
    output logic       match,
    output logic       irq
);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cmp_q, cmp_d;
    logic [2:0] ctrl_q, ctrl_d;
    logic       match_q, match_d;
    logic       hit;

    // Next-state: CPU count load beats counting; match set beats W1C clear.
    always_comb begin
        cnt_d   = cnt_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        match_d = match_q;
        hit     = 1'b0;

        if (status_w1c && wdata[0]) begin
            match_d = 1'b0;
        end

        if (cnt_we) begin
            cnt_d = wdata;
        end else if (ctrl_q[CTRL_EN]) begin
            if (cnt_q == cmp_q) begin
                hit   = 1'b1;
                cnt_d = ctrl_q[CTRL_AUTO_CLR] ? '0 : cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        if (hit) begin
            match_d = 1'b1;
        end

        if (cmp_we) begin
            cmp_d = wdata;
        end
        if (ctrl_we) begin
            ctrl_d = wdata[2:0];
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            cmp_q   <= TIMER_CMP_RST;
            ctrl_q  <= '0;
            match_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            match_q <= match_d;
        end
    end

    assign cnt   = cnt_q;
    assign cmp   = cmp_q;
    assign ctrl  = {5'b0, ctrl_q};
    assign match = match_q;
    assign irq   = match_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/dmem_io.sv
// Data memory responder: RAM below RAM_TOP, I/O page (output port,
// synchronized input port, compare timer) above it.
module dmem_io
    import dmem_io_pkg::*;
#(
    parameter logic [7:0] RAM_TOP = 8'hEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       MW,
    input  logic [7:0] Address,
    input  logic [7:0] Data_in,
    output logic [7:0] Data_out,
    input  logic [7:0] port_in,
    output logic [7:0] port_out,
    output logic       irq
);

    logic [7:0] ram_q [0:RAM_TOP];
    logic [7:0] ram_d [0:RAM_TOP];
    logic [7:0] port_out_q, port_out_d;
    logic [7:0] sync1_q, sync2_q;
    logic       in_ram;
    logic       io_we;
    logic [7:0] tmr_cnt, tmr_cmp, tmr_ctrl;
    logic       tmr_match;

    assign in_ram = (Address <= RAM_TOP);
    assign io_we  = MW && !in_ram;

    io_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .cnt_we     (io_we && (Address == ADDR_TIMER_CNT)),
        .cmp_we     (io_we && (Address == ADDR_TIMER_CMP)),
        .ctrl_we    (io_we && (Address == ADDR_CTRL)),
        .status_w1c (io_we && (Address == ADDR_STATUS)),
        .wdata      (Data_in),
        .cnt        (tmr_cnt),
        .cmp        (tmr_cmp),
        .ctrl       (tmr_ctrl),
        .match      (tmr_match),
        .irq        (irq)
    );

    // Next-state for RAM and the output port register.
    always_comb begin
        ram_d      = ram_q;
        port_out_d = port_out_q;
        if (MW && in_ram) begin
            ram_d[Address] = Data_in;
        end
        if (io_we && (Address == ADDR_PORT_OUT)) begin
            port_out_d = Data_in;
        end
    end

    // State registers and two-stage input synchronizer; reset clears all.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_q      <= '{default: '0};
            port_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            ram_q      <= ram_d;
            port_out_q <= port_out_d;
            sync1_q    <= port_in;
            sync2_q    <= sync1_q;
        end
    end

    // Combinational read mux; reserved addresses read zero.
    always_comb begin
        Data_out = '0;
        if (in_ram) begin
            Data_out = ram_q[Address];
        end else begin
            case (Address)
                ADDR_PORT_OUT:  Data_out = port_out_q;
                ADDR_PORT_IN:   Data_out = sync2_q;
                ADDR_TIMER_CNT: Data_out = tmr_cnt;
                ADDR_TIMER_CMP: Data_out = tmr_cmp;
                ADDR_CTRL:      Data_out = tmr_ctrl;
                ADDR_STATUS:    Data_out = {7'b0, tmr_match};
                default:        Data_out = '0;
            endcase
        end
    end

    assign port_out = port_out_q;

endmodule

// File: tb/tb_dmem_io.sv
// Directed bench for dmem_io: RAM, ports, timer, simultaneous events, reset.
module tb_dmem_io;

    logic       clk = 1'b0;
    logic       reset;
    logic       MW;
    logic [7:0] Address;
    logic [7:0] Data_in;
    logic [7:0] Data_out;
    logic [7:0] port_in;
    logic [7:0] port_out;
    logic       irq;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    dmem_io #(.RAM_TOP(8'hEF)) dut (
        .clk      (clk),
        .reset    (reset),
        .MW       (MW),
        .Address  (Address),
        .Data_in  (Data_in),
        .Data_out (Data_out),
        .port_in  (port_in),
        .port_out (port_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        Address = a;
        Data_in = d;
        MW = 1'b1;
        tick();
        MW = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        MW = 1'b0;
        Address = a;
        #1;
        d = Data_out;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b0;
        tick();
        tick();
        total_cnt++; if (port_out !== 8'h00) $display("FAIL reset_port_out got %h exp 00", port_out); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq); else pass_cnt++;
        rd(8'h10, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL reset_ram got %h exp 00", v); else pass_cnt++;
        rd(8'hF2, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL reset_cnt got %h exp 00", v); else pass_cnt++;
        rd(8'hF3, v);
        total_cnt++; if (v !== 8'hFF) $display("FAIL reset_cmp got %h exp FF", v); else pass_cnt++;
        rd(8'hF5, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL reset_status got %h exp 00", v); else pass_cnt++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_ram();
        logic [7:0] v;
        wr(8'h10, 8'hA5);
        wr(8'hEF, 8'h3C);
        rd(8'h10, v);
        total_cnt++; if (v !== 8'hA5) $display("FAIL ram_10 got %h exp A5", v); else pass_cnt++;
        rd(8'hEF, v);
        total_cnt++; if (v !== 8'h3C) $display("FAIL ram_ef got %h exp 3C", v); else pass_cnt++;
        rd(8'h11, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL ram_11 got %h exp 00", v); else pass_cnt++;
        rd(8'hF8, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL rsvd_read got %h exp 00", v); else pass_cnt++;
        wr(8'hF8, 8'h99);
        rd(8'hF8, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL rsvd_write got %h exp 00", v); else pass_cnt++;
        // Same-cycle read sees the old value, next cycle the new one.
        Address = 8'h20;
        Data_in = 8'h77;
        MW = 1'b1;
        #1;
        total_cnt++; if (Data_out !== 8'h00) $display("FAIL ram_old_read got %h exp 00", Data_out); else pass_cnt++;
        tick();
        MW = 1'b0;
        #1;
        total_cnt++; if (Data_out !== 8'h77) $display("FAIL ram_new_read got %h exp 77", Data_out); else pass_cnt++;
    endtask

    task automatic test_port();
        logic [7:0] v;
        wr(8'hF0, 8'h5A);
        total_cnt++; if (port_out !== 8'h5A) $display("FAIL port_out got %h exp 5A", port_out); else pass_cnt++;
        rd(8'hF0, v);
        total_cnt++; if (v !== 8'h5A) $display("FAIL port_out_read got %h exp 5A", v); else pass_cnt++;
        port_in = 8'hC3;
        tick();
        rd(8'hF1, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL port_in_edge1 got %h exp 00", v); else pass_cnt++;
        tick();
        rd(8'hF1, v);
        total_cnt++; if (v !== 8'hC3) $display("FAIL port_in_edge2 got %h exp C3", v); else pass_cnt++;
        wr(8'hF1, 8'h11);
        rd(8'hF1, v);
        total_cnt++; if (v !== 8'hC3) $display("FAIL port_in_ro got %h exp C3", v); else pass_cnt++;
    endtask

    task automatic test_timer_autoclr();
        logic [7:0] v;
        logic [7:0] exp_cnt [5] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h01};
        logic       exp_irq [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        wr(8'hF3, 8'h03);
        wr(8'hF4, 8'h07);
        rd(8'hF2, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL tmr_start got %h exp 00", v); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick();
            rd(8'hF2, v);
            total_cnt++; if (v !== exp_cnt[i]) $display("FAIL tmr_cnt[%0d] got %h exp %h", i, v, exp_cnt[i]); else pass_cnt++;
            total_cnt++; if (irq !== exp_irq[i]) $display("FAIL tmr_irq[%0d] got %b exp %b", i, irq, exp_irq[i]); else pass_cnt++;
        end
        wr(8'hF5, 8'h01);
        total_cnt++; if (irq !== 1'b0) $display("FAIL w1c_clear got %b exp 0", irq); else pass_cnt++;
        rd(8'hF2, v);
        total_cnt++; if (v !== 8'h02) $display("FAIL w1c_cnt got %h exp 02", v); else pass_cnt++;
        tick();
        total_cnt++; if (irq !== 1'b0) $display("FAIL pre_match_irq got %b exp 0", irq); else pass_cnt++;
        wr(8'hF5, 8'h01);
        total_cnt++; if (irq !== 1'b1) $display("FAIL set_wins_irq got %b exp 1", irq); else pass_cnt++;
        rd(8'hF5, v);
        total_cnt++; if (v !== 8'h01) $display("FAIL set_wins_status got %h exp 01", v); else pass_cnt++;
        rd(8'hF2, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL set_wins_cnt got %h exp 00", v); else pass_cnt++;
    endtask

    task automatic test_wrap_and_load();
        logic [7:0] v;
        wr(8'hF4, 8'h00);
        wr(8'hF5, 8'h01);
        rd(8'hF5, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL stop_status got %h exp 00", v); else pass_cnt++;
        wr(8'hF3, 8'h10);
        wr(8'hF2, 8'hFE);
        wr(8'hF4, 8'hF9);
        rd(8'hF4, v);
        total_cnt++; if (v !== 8'h01) $display("FAIL ctrl_mask got %h exp 01", v); else pass_cnt++;
        rd(8'hF2, v);
        total_cnt++; if (v !== 8'hFE) $display("FAIL ctrl_old_edge got %h exp FE", v); else pass_cnt++;
        tick();
        rd(8'hF2, v);
        total_cnt++; if (v !== 8'hFF) $display("FAIL wrap_ff got %h exp FF", v); else pass_cnt++;
        tick();
        rd(8'hF2, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL wrap_00 got %h exp 00", v); else pass_cnt++;
        rd(8'hF5, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL wrap_match got %h exp 00", v); else pass_cnt++;
        wr(8'hF2, 8'h40);
        rd(8'hF2, v);
        total_cnt++; if (v !== 8'h40) $display("FAIL cnt_load got %h exp 40", v); else pass_cnt++;
        tick();
        rd(8'hF2, v);
        total_cnt++; if (v !== 8'h41) $display("FAIL cnt_after_load got %h exp 41", v); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        wr(8'hF0, 8'hAA);
        wr(8'hF3, 8'h01);
        wr(8'hF2, 8'h00);
        wr(8'hF4, 8'h07);
        tick();
        total_cnt++; if (irq !== 1'b1) $display("FAIL pre_reset_irq got %b exp 1", irq); else pass_cnt++;
        reset = 1'b0;
        Address = 8'h10;
        Data_in = 8'h55;
        MW = 1'b1;
        tick();
        MW = 1'b0;
        total_cnt++; if (irq !== 1'b0) $display("FAIL rst_irq got %b exp 0", irq); else pass_cnt++;
        total_cnt++; if (port_out !== 8'h00) $display("FAIL rst_port_out got %h exp 00", port_out); else pass_cnt++;
        rd(8'hF2, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL rst_cnt got %h exp 00", v); else pass_cnt++;
        rd(8'hF3, v);
        total_cnt++; if (v !== 8'hFF) $display("FAIL rst_cmp got %h exp FF", v); else pass_cnt++;
        rd(8'h10, v);
        total_cnt++; if (v !== 8'h00) $display("FAIL rst_ram got %h exp 00", v); else pass_cnt++;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset   = 1'b0;
        MW      = 1'b0;
        Address = 8'h00;
        Data_in = 8'h00;
        port_in = 8'h00;
        test_reset();
        test_ram();
        test_port();
        test_timer_autoclr();
        test_wrap_and_load();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_io.md
# dmem_io

Data-side bus responder for the 8-bit CPU. It answers the CPU's address/data/MW write-strobe bus with 240 bytes of RAM plus a memory-mapped I/O page holding an output port, a synchronized input port and an 8-bit compare timer with interrupt. It sits where the plain data memory sits today, on the far end of the CPU's `Address_out`/`Data_out`/`MW`/`Data_in` interface.

## Interface
- `RAM_TOP`, default 8'hEF: last RAM address; addresses above it decode to the I/O page.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `MW`  in  1: write strobe from the CPU; 1 = write `Data_in` to `Address` on this edge.
- `Address`  in  8: byte address from the CPU.
- `Data_in`  in  8: write data from the CPU.
- `Data_out`  out  8: read data to the CPU, combinational from `Address`.
- `port_in`  in  8: external input pins, asynchronous to `clk`.
- `port_out`  out  8: external output port register.
- `irq`  out  1: level interrupt, equal to `STATUS.match & CTRL.irq_en`.

## Operation
- Address map:
  - 0x00–0xEF RAM, read/write.
  - 0xF0 PORT_OUT, read/write.
  - 0xF1 PORT_IN, read-only; returns the value after the synchronizer.
  - 0xF2 TIMER_CNT, read/write.
  - 0xF3 TIMER_CMP, read/write.
  - 0xF4 CTRL, read/write: bit0 `en`, bit1 `auto_clr`, bit2 `irq_en`, bits 7:3 read 0.
  - 0xF5 STATUS: bit0 `match`; write 1 to clear, write 0 has no effect.
  - 0xF6–0xFF reserved: read 8'h00, writes ignored.
- Reads are combinational and have no side effects.
- Writes commit on the rising edge when `MW`=1. Writes to read-only or reserved locations are dropped.
- Input synchronizer: `port_in` passes through two flops before it reaches PORT_IN.
- Timer behaviour, evaluated at each edge while `en`=1:
  - If `cnt == cmp`: set `match`; next `cnt` is 0 if `auto_clr`=1, else `cnt+1`.
  - Otherwise: `cnt <= cnt+1`.
  - Arithmetic is mod 256, so 8'hFF wraps to 8'h00.
  - While `en`=0, `cnt` holds.
- Simultaneous events:
  - A CPU write to TIMER_CNT overrides the increment, the auto-clear and the match evaluation for that edge. The written value is loaded as-is.
  - A W1C to STATUS on the same edge that a match is detected leaves `match`=1 (set wins).
  - A write to CTRL takes effect from the next edge; the current edge uses the old CTRL value.
- Reset (`reset`=0 at an edge):
  - RAM is cleared to 0.
  - PORT_OUT, TIMER_CNT, CTRL, STATUS and both synchronizer stages are cleared to 0.
  - TIMER_CMP is set to 8'hFF.
  - Reset overrides any write presented on the same edge.
  - Reset mid-count zeroes the timer and drops `irq`.

## Timing
- Write latency: the value is visible on `Data_out` in the cycle after the write edge. The same-cycle read returns the old value.
- Read latency: 0 cycles (combinational from `Address`).
- `port_in` to PORT_IN read: 2 edges.
- Match detect to `irq`: the `irq` level rises directly after the edge that sets `match`. It is combinational from the flops.
- Reset output values:
  - `port_out`=0, `irq`=0.
  - `Data_out` = 0 for any RAM, PORT_*, CNT, CTRL, STATUS or reserved address.
  - `Data_out` = 8'hFF at 0xF3.

## Structure
- Package `dmem_io_pkg` holds:
  - Register address constants `ADDR_PORT_OUT` … `ADDR_STATUS`.
  - CTRL bit index constants `CTRL_EN`, `CTRL_AUTO_CLR`, `CTRL_IRQ_EN`.
  - The TIMER_CMP reset value 8'hFF.
- One sub-module, `io_timer`.
  - Contents: count, compare, CTRL and STATUS registers; load/W1C inputs; `match` and `irq` outputs.
  - `dmem_io` keeps the RAM array, the address decode, the read mux, PORT_OUT and the synchronizer.

## Test plan
- RAM round-trip: after reset, write 8'hA5 to 0x10 and 8'h3C to 0xEF, then read both → 8'hA5 and 8'h3C. Read 0x11 → 8'h00. Read 0xF8 → 8'h00. Writing 0xF8 leaves it reading 8'h00.
- Port path:
  - Write 8'h5A to 0xF0 → `port_out`=8'h5A on the next cycle.
  - Drive `port_in`=8'hC3 → reading 0xF1 returns 8'hC3 only from the 2nd edge onward.
- Timer with auto-clear:
  - Setup: CMP=3, CTRL=8'h07.
  - `cnt` sequence 0,1,2,3,0,1,…
  - `match`/`irq` rise after the edge where `cnt`=3.
  - W1C 0x01 to 0xF5 → `irq` falls after the next edge, unless that edge is another match.
- Simultaneous events:
  - TIMER_CNT=8'hFE with `en`=1, auto_clr=0, CMP=8'h10 → 8'hFF, then 8'h00 (wrap); `match` stays 0.
  - Write 8'h40 to CNT while counting → reads 8'h40 next cycle.
  - W1C on the match edge → `match` remains 1.
- Reset mid-operation:
  - Assert `reset`=0 while the timer is running, `irq`=1 and MW=1 writes 0x10.
  - After that edge: `irq`=0, CNT=0, CMP=8'hFF, `port_out`=0, and 0x10 reads 0.
